// File: rtl/lke_pkg.sv
// Shared constants for the lookup-engine (lke_*) blocks.
//   PHV_LEN / ACT_LEN : PHV and action-entry widths
//   ADDR_W            : action RAM address width (256 entries)
//   RAM_LAT_DEFAULT   : default port-B read latency of the action RAM
//   FIFO_DEPTH_DEFAULT: default depth of the scheduler output FIFO
//   MISS_ACT          : action emitted for lookups without a match
package lke_pkg;

    localparam int unsigned PHV_LEN            = 4 * 8 * 64 + 256;
    localparam int unsigned ACT_LEN            = 64 * 65;
    localparam int unsigned ADDR_W             = 8;
    localparam int unsigned RAM_LAT_DEFAULT    = 2;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

    localparam logic [ACT_LEN-1:0] MISS_ACT = ACT_LEN'(32'h3f);

    // Saturating 32-bit increment used by the statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/lke_out_fifo.sv
// Synchronous FIFO with asynchronous active-low reset.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/wdata_i: write one entry (caller guarantees space)
//   pop_i         : drop head entry (ignored when empty)
//   rdata_o       : head entry, valid while !empty_o
//   full_o/empty_o/count_o : occupancy status
// Depth must be a power of two so the pointers wrap naturally.
module lke_out_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            // Push and pop in the same cycle leave the count unchanged, even when full.
            count_q <= count_q + CntW'(push_i) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/lke_act_rd_sched.sv
// Action-RAM read scheduler: one port-B read per cycle, PHV carried in a tag pipe
// alongside the read, results queued in an output FIFO with ready/valid handshake.
//   clk, rst_n                 : clock, async active-low reset
//   phv_in/phv_valid/match_addr/if_match/ready_out : request side
//   ram_addrb/ram_doutb        : action RAM port B (RAM_LAT read latency)
//   c_wr_en_act/c_index_act    : snooped port-A writes (same-address collision stall)
//   action/phv_out/action_valid/ready_in : result side
//   hit_cnt/miss_cnt           : saturating counts of accepted hits / misses
module lke_act_rd_sched
    import lke_pkg::*;
#(
    parameter int unsigned RAM_LAT    = RAM_LAT_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic               phv_valid,
    input  logic [ADDR_W-1:0]  match_addr,
    input  logic               if_match,
    output logic               ready_out,
    output logic [ADDR_W-1:0]  ram_addrb,
    input  logic [ACT_LEN-1:0] ram_doutb,
    input  logic               c_wr_en_act,
    input  logic [ADDR_W-1:0]  c_index_act,
    output logic [ACT_LEN-1:0] action,
    output logic [PHV_LEN-1:0] phv_out,
    output logic               action_valid,
    input  logic               ready_in,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SumW = CntW + 1;
    localparam int unsigned EntW = ACT_LEN + PHV_LEN;

    logic [RAM_LAT-1:0] vld_q;
    logic [RAM_LAT-1:0] hit_q;
    logic [PHV_LEN-1:0] phv_q [RAM_LAT];
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        hit_cnt_q, hit_cnt_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;

    logic               accept;
    logic               collide;
    logic [SumW-1:0]    inflight;
    logic [CntW-1:0]    fifo_cnt;
    logic               push, pop;
    logic               fifo_empty, fifo_full;
    logic [EntW-1:0]    push_data;
    logic [EntW-1:0]    head;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RAM_LAT); i++) begin
            inflight = inflight + SumW'(vld_q[i]);
        end
    end

    // Credits cover both reads in flight and queued results, so a pipe exit never
    // finds the FIFO full. A same-address port-A write would race the read, so stall.
    assign collide   = c_wr_en_act && (c_index_act == match_addr);
    assign ready_out = ((inflight + SumW'(fifo_cnt)) < SumW'(FIFO_DEPTH)) && !collide;
    assign accept    = phv_valid && ready_out;
    assign ram_addrb = accept ? match_addr : addr_q;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (accept) begin
            if (if_match) begin
                hit_cnt_d = sat_inc(hit_cnt_q);
            end else begin
                miss_cnt_d = sat_inc(miss_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            hit_q      <= '0;
            addr_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int i = 0; i < int'(RAM_LAT); i++) begin
                phv_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= accept;
            hit_q[0] <= if_match;
            phv_q[0] <= phv_in;
            for (int i = 1; i < int'(RAM_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                hit_q[i] <= hit_q[i-1];
                phv_q[i] <= phv_q[i-1];
            end
            if (accept) begin
                addr_q <= match_addr;
            end
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Last tag stage lines up with ram_doutb for the same request.
    assign push      = vld_q[RAM_LAT-1];
    assign push_data = {(hit_q[RAM_LAT-1] ? ram_doutb : MISS_ACT), phv_q[RAM_LAT-1]};
    assign pop       = action_valid && ready_in;

    lke_out_fifo #(
        .Width (EntW),
        .Depth (FIFO_DEPTH)
    ) u_out_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign action_valid = !fifo_empty;
    assign action       = head[EntW-1 -: ACT_LEN];
    assign phv_out      = head[PHV_LEN-1:0];
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;

    push_no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

endmodule
